// File: rtl/sd_rx_dma_writer_pkg.sv
// Shared definitions for the SD receive DMA writer.
//   dmaState_e     : writer state machine encoding (IDLE / REQ / WAIT_ACK)
//   WORD_ADDR_INCR : byte-address step between consecutive 32-bit words
package sd_rx_dma_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } dmaState_e;

  localparam int unsigned WORD_ADDR_INCR = 4;

endpackage

// File: rtl/sd_dma_fifo.sv
// Synchronous first-word-fall-through FIFO buffering receive words ahead of
// the bus writer.
//   i_clk, i_reset : clock, synchronous active-high reset
//   flush_i        : zero pointers and count; a push in the same cycle is lost
//   push_i/data_i  : enqueue a word (accepted when not full, or when a pop
//                    happens in the same cycle)
//   pop_i          : dequeue the head word; head is always visible on data_o
//   full_o/empty_o : occupancy flags, count_o : number of stored words
module sd_dma_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  doPush, doPop;

  assign full_o  = (count_q == COUNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rdPtr_q];

  // A push at full still fits when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o && !flush_i;
  assign doPush = push_i && !flush_i && (!full_o || doPop);

  // Pointer and occupancy bookkeeping; flush simply rewinds everything.
  always_ff @(posedge i_clk) begin
    if (i_reset || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (!i_reset && doPush) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/sd_rx_dma_writer.sv
// Buffers 32-bit SD receive words and writes them sequentially into SDRAM
// through the memory bus arbiter, one outstanding write at a time.
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_fifo_flush/push/data   : upstream FIFO control and write data
//   o_fifo_full/empty        : flow control and drain status
//   o_overflow               : sticky dropped-push flag, cleared by i_start
//   i_start/i_start_address  : new transfer base address, clears counters
//   o_word_count             : words acknowledged since the last start
//   o_request/o_write/o_address/o_data, i_busy/i_ack : bus write port
module sd_rx_dma_writer
  import sd_rx_dma_writer_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int ADDRESS_WIDTH   = 24
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_fifo_flush,
  input  logic                     i_fifo_push,
  input  logic [31:0]              i_fifo_data,
  output logic                     o_fifo_full,
  output logic                     o_fifo_empty,
  output logic                     o_overflow,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_start_address,
  output logic [15:0]              o_word_count,
  output logic                     o_request,
  output logic                     o_write,
  input  logic                     i_busy,
  input  logic                     i_ack,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [31:0]              o_data
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_INCR  = ADDRESS_WIDTH'(WORD_ADDR_INCR);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  dmaState_e                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [ADDRESS_WIDTH-1:0]  pendingAddr_q, pendingAddr_d;
  logic                      pendingStart_q, pendingStart_d;
  logic [31:0]               data_q, data_d;
  logic                      request_q, request_d;
  logic [15:0]               wordCount_q, wordCount_d;
  logic                      overflow_q, overflow_d;

  logic                      fifoPop, fifoFull, fifoEmpty;
  logic [31:0]               fifoRdata;
  logic [FIFO_DEPTH_LOG2:0]  fifoCount;
  logic [ADDRESS_WIDTH-1:0]  alignedStart;
  logic                      pushDropped;

  sd_dma_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .flush_i (i_fifo_flush),
    .push_i  (i_fifo_push),
    .data_i  (i_fifo_data),
    .pop_i   (fifoPop),
    .data_o  (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign alignedStart = i_start_address & ALIGN_MASK;
  assign pushDropped  = i_fifo_push && !i_fifo_flush && fifoFull && !fifoPop;

  assign o_fifo_full  = fifoFull;
  assign o_fifo_empty = (fifoCount == '0) && (state_q == ST_IDLE) && !pendingStart_q;
  assign o_overflow   = o_overflow_w();
  assign o_word_count = wordCount_q;
  assign o_request    = request_q;
  assign o_write      = 1'b1;
  assign o_address    = address_q;
  assign o_data       = data_q;

  function automatic logic o_overflow_w();
    return overflow_q;
  endfunction

  // Writer FSM. A start seen mid-transfer is parked and applied in IDLE,
  // where it takes the whole cycle so the next request waits one cycle.
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    pendingAddr_d  = pendingAddr_q;
    pendingStart_d = pendingStart_q;
    data_d         = data_q;
    request_d      = request_q;
    wordCount_d    = wordCount_q;
    overflow_d     = overflow_q;
    fifoPop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          address_d      = alignedStart;
          wordCount_d    = '0;
          pendingStart_d = 1'b0;
        end else if (pendingStart_q) begin
          address_d      = pendingAddr_q;
          wordCount_d    = '0;
          pendingStart_d = 1'b0;
        end else if (!fifoEmpty && !i_fifo_flush) begin
          fifoPop   = 1'b1;
          data_d    = fifoRdata;
          request_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!i_busy) begin
          request_d = 1'b0;
          state_d   = ST_WAIT_ACK;
        end
        if (i_start) begin
          pendingStart_d = 1'b1;
          pendingAddr_d  = alignedStart;
        end
      end
      ST_WAIT_ACK: begin
        if (i_ack) begin
          address_d   = address_q + ADDR_INCR;
          wordCount_d = wordCount_q + 16'd1;
          state_d     = ST_IDLE;
        end
        if (i_start) begin
          pendingStart_d = 1'b1;
          pendingAddr_d  = alignedStart;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A dropped push in the same cycle as a start stays visible.
    if (i_start)     overflow_d = 1'b0;
    if (pushDropped) overflow_d = 1'b1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      address_q      <= '0;
      pendingAddr_q  <= '0;
      pendingStart_q <= 1'b0;
      data_q         <= '0;
      request_q      <= 1'b0;
      wordCount_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      address_q      <= address_d;
      pendingAddr_q  <= pendingAddr_d;
      pendingStart_q <= pendingStart_d;
      data_q         <= data_d;
      request_q      <= request_d;
      wordCount_q    <= wordCount_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sd_rx_dma_writer.sv
// Directed self-checking bench for sd_rx_dma_writer: reset values, single
// write latency, fill/overflow, push+pop at full, flush, start while busy,
// address wrap and reset in the middle of a transaction.
module tb_sd_rx_dma_writer;

  logic        i_clk = 1'b0;
  logic        i_reset, i_fifo_flush, i_fifo_push, i_start, i_busy, i_ack;
  logic [31:0] i_fifo_data;
  logic [23:0] i_start_address;
  logic        o_fifo_full, o_fifo_empty, o_overflow, o_request, o_write;
  logic [15:0] o_word_count;
  logic [23:0] o_address;
  logic [31:0] o_data;

  int totalChecks = 0;
  int badChecks   = 0;

  sd_rx_dma_writer #(.FIFO_DEPTH_LOG2(3), .ADDRESS_WIDTH(24)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_fifo_flush    (i_fifo_flush),
    .i_fifo_push     (i_fifo_push),
    .i_fifo_data     (i_fifo_data),
    .o_fifo_full     (o_fifo_full),
    .o_fifo_empty    (o_fifo_empty),
    .o_overflow      (o_overflow),
    .i_start         (i_start),
    .i_start_address (i_start_address),
    .o_word_count    (o_word_count),
    .o_request       (o_request),
    .o_write         (o_write),
    .i_busy          (i_busy),
    .i_ack           (i_ack),
    .o_address       (o_address),
    .o_data          (o_data)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] startAddr);
    i_start = 1'b1;
    i_start_address = startAddr;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] word);
    i_fifo_push = 1'b1;
    i_fifo_data = word;
    tick();
    i_fifo_push = 1'b0;
  endtask

  // Plays the bus: waits (bounded) for a request, checks it, accepts it and
  // acks two cycles after the accept.
  task automatic serviceWrite(input logic [23:0] expAddr, input logic [31:0] expData,
                              input string tag);
    int waitCycles = 0;
    while (!o_request && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!o_request) begin
      checkOutput({tag, "_timeout"}, 32'(o_request), 32'd1);
      return;
    end
    checkOutput({tag, "_addr"}, 32'(o_address), 32'(expAddr));
    checkOutput({tag, "_data"}, o_data, expData);
    i_busy = 1'b0;
    tick();
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b1; i_fifo_flush = 1'b0; i_fifo_push = 1'b0; i_fifo_data = '0;
    i_start = 1'b0; i_start_address = '0; i_busy = 1'b0; i_ack = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    tick();

    // Reset values
    checkOutput("rst_req",   32'(o_request),    32'd0);
    checkOutput("rst_write", 32'(o_write),      32'd1);
    checkOutput("rst_addr",  32'(o_address),    32'd0);
    checkOutput("rst_data",  o_data,            32'd0);
    checkOutput("rst_full",  32'(o_fifo_full),  32'd0);
    checkOutput("rst_empty", 32'(o_fifo_empty), 32'd1);
    checkOutput("rst_ovf",   32'(o_overflow),   32'd0);
    checkOutput("rst_wc",    32'(o_word_count), 32'd0);

    // Single word, request appears two cycles after the push
    applyStimulus(24'h001000);
    pushWord(32'hDEADBEEF);
    checkOutput("one_req_n1",   32'(o_request),    32'd0);
    checkOutput("one_empty_n1", 32'(o_fifo_empty), 32'd0);
    tick();
    checkOutput("one_req_n2", 32'(o_request), 32'd1);
    serviceWrite(24'h001000, 32'hDEADBEEF, "one");
    checkOutput("one_addr_after", 32'(o_address),    32'h001004);
    checkOutput("one_wc_after",   32'(o_word_count), 32'd1);
    checkOutput("one_empty",      32'(o_fifo_empty), 32'd1);

    // Fill with bus stalled: 8 stored + 1 held in o_data, 10th dropped
    applyStimulus(24'h000100);
    checkOutput("fill_wc_clr", 32'(o_word_count), 32'd0);
    i_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pushWord(32'h100 + 32'(i));
      if (i == 7) checkOutput("fill_full_8", 32'(o_fifo_full), 32'd0);
      if (i == 8) begin
        checkOutput("fill_full_9", 32'(o_fifo_full), 32'd1);
        checkOutput("fill_ovf_9",  32'(o_overflow),  32'd0);
      end
    end
    checkOutput("fill_ovf_10", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 9; k++)
      serviceWrite(24'h000100 + 24'(4 * k), 32'h100 + 32'(k), $sformatf("fill%0d", k));
    tick(); tick(); tick();
    checkOutput("fill_no_extra", 32'(o_request),    32'd0);
    checkOutput("fill_empty",    32'(o_fifo_empty), 32'd1);
    checkOutput("fill_wc",       32'(o_word_count), 32'd9);
    checkOutput("fill_ovf_kept", 32'(o_overflow),   32'd1);

    // Push while full in the same cycle the head is popped
    applyStimulus(24'h000200);
    checkOutput("pp_ovf_clr", 32'(o_overflow), 32'd0);
    i_busy = 1'b1;
    for (int i = 0; i < 9; i++) pushWord(32'hA0 + 32'(i));
    checkOutput("pp_full", 32'(o_fifo_full), 32'd1);
    checkOutput("pp_data", o_data, 32'hA0);
    i_busy = 1'b0;
    tick(); tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    pushWord(32'hA9);
    checkOutput("pp_full_kept", 32'(o_fifo_full), 32'd1);
    checkOutput("pp_no_ovf",    32'(o_overflow),  32'd0);
    for (int k = 1; k < 10; k++)
      serviceWrite(24'h000200 + 24'(4 * k), 32'hA0 + 32'(k), $sformatf("pp%0d", k));
    checkOutput("pp_wc", 32'(o_word_count), 32'd10);

    // Flush while the first of four words is waiting for its ack
    applyStimulus(24'h000300);
    for (int i = 0; i < 4; i++) pushWord(32'hB0 + 32'(i));
    checkOutput("fl_data", o_data, 32'hB0);
    i_fifo_flush = 1'b1;
    tick();
    i_fifo_flush = 1'b0;
    checkOutput("fl_busy", 32'(o_fifo_empty), 32'd0);
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    checkOutput("fl_wc",    32'(o_word_count), 32'd1);
    checkOutput("fl_addr",  32'(o_address),    32'h000304);
    checkOutput("fl_empty", 32'(o_fifo_empty), 32'd1);
    tick(); tick();
    checkOutput("fl_no_req", 32'(o_request), 32'd0);

    // Start arriving while a write waits for its ack
    applyStimulus(24'h002000);
    pushWord(32'hC0);
    tick();
    checkOutput("sw_req",  32'(o_request), 32'd1);
    checkOutput("sw_addr", 32'(o_address), 32'h002000);
    tick();
    i_start = 1'b1; i_start_address = 24'h003002;
    i_fifo_push = 1'b1; i_fifo_data = 32'hC1;
    tick();
    i_start = 1'b0; i_fifo_push = 1'b0;
    checkOutput("sw_pending", 32'(o_fifo_empty), 32'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    checkOutput("sw_addr_load", 32'(o_address),    32'h003000);
    checkOutput("sw_wc_clr",    32'(o_word_count), 32'd0);
    checkOutput("sw_bubble",    32'(o_request),    32'd0);
    serviceWrite(24'h003000, 32'hC1, "sw_next");
    checkOutput("sw_wc_after", 32'(o_word_count), 32'd1);

    // Address wraps at the top of the 24-bit space
    applyStimulus(24'hFFFFFC);
    pushWord(32'hD0);
    pushWord(32'hD1);
    serviceWrite(24'hFFFFFC, 32'hD0, "wrap0");
    serviceWrite(24'h000000, 32'hD1, "wrap1");
    checkOutput("wrap_addr", 32'(o_address),    32'h000004);
    checkOutput("wrap_wc",   32'(o_word_count), 32'd2);

    // Reset with a request outstanding
    pushWord(32'hE0);
    tick();
    i_busy = 1'b1;
    checkOutput("mr_req_before", 32'(o_request), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_busy = 1'b0;
    checkOutput("mr_req",   32'(o_request),    32'd0);
    checkOutput("mr_addr",  32'(o_address),    32'd0);
    checkOutput("mr_data",  o_data,            32'd0);
    checkOutput("mr_empty", 32'(o_fifo_empty), 32'd1);
    checkOutput("mr_wc",    32'(o_word_count), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
